ponto_fixo_alu_seq: RTL and testbench

Parametrised signed fixed-point arithmetic unit in Q`INT_BITS`.`FRAC_BITS` format. It performs add, subtract and multiply with selectable saturation or wrap-around, and reports an overflow flag per operation. Add and subtract complete in one cycle. Multiply uses a multi-cycle shift-add FSM. It is the general-width, multi-operation successor of the 8-bit Q4.4 add/sub block, with a start/busy/done handshake to the surrounding datapath.

---
 rtl/ponto_fixo_alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_ponto_fixo_alu_seq.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ponto_fixo_alu_seq.sv
// ponto_fixo_alu_seq
// Signed fixed-point arithmetic unit, Q(INT_BITS).(FRAC_BITS).
// Add, subtract and the reserved op finish in a single cycle; multiply runs
// an unsigned shift-add over the operand magnitudes for W iterations, then
// rounds half away from zero, rescales, restores the sign and range-checks.
// Saturation versus wrap-around is fixed at elaboration time by SAT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; operands and op are sampled on acceptance
// MUL     | shift-add iterations, then the finalize step
// DONE    | result/overflow freshly updated; done=1 for this one cycle

module ponto_fixo_alu_seq #(
    parameter int INT_BITS  = 4,
    parameter int FRAC_BITS = 4,
    parameter bit SAT       = 1'b1,
    localparam int W        = INT_BITS + FRAC_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Iteration counter width: must hold the value W itself.
    localparam int CW = $clog2(W + 1);
    // Width of the rescaled magnitude: (2W+1)-bit rounded product >> FRAC_BITS.
    localparam int SW = 2 * W + 1 - FRAC_BITS;

    localparam logic [W-1:0]   MAX_W    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   MIN_W    = {1'b1, {(W-1){1'b0}}};
    localparam logic [2*W:0]   HALF_LSB = (2*W+1)'(1) << (FRAC_BITS - 1);
    localparam logic [SW-1:0]  MAG_MIN  = SW'(1) << (W - 1);
    localparam logic [SW-1:0]  MAG_MAX  = MAG_MIN - SW'(1);

    logic [1:0]     state;

    // Multiply datapath registers
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplr;
    logic [CW-1:0]  cnt;
    logic           neg_q;

    // Single-cycle add/sub path
    logic [W:0]     a_ext;
    logic [W:0]     b_ext;
    logic [W:0]     sum_as;
    logic           as_ovf;
    logic [W-1:0]   as_res;

    // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;

    // Multiply finalize path
    logic [SW-1:0]  scaled;
    logic [W-1:0]   mul_wrap;
    logic           mul_ovf;
    logic [W-1:0]   mul_res;

    // Sign-extended add/sub with overflow detection and optional clamping
    always_comb begin
        a_ext  = {a[W-1], a};
        b_ext  = {b[W-1], b};
        sum_as = '0;
        if (op == OP_SUB) begin
            sum_as = a_ext - b_ext;
        end else begin
            sum_as = a_ext + b_ext;
        end
        // The extra top bit carries the true sign; disagreement means overflow.
        as_ovf = sum_as[W] ^ sum_as[W-1];
        as_res = sum_as[W-1:0];
        if (SAT && as_ovf) begin
            as_res = sum_as[W] ? MIN_W : MAX_W;
        end
    end

    // Operand magnitudes loaded into the shift-add registers on acceptance
    always_comb begin
        mag_a = a[W-1] ? -a : a;
        mag_b = b[W-1] ? -b : b;
    end

    // Round, rescale, re-sign and range-check the accumulated magnitude
    always_comb begin
        // Adding half an output LSB before truncation rounds the magnitude
        // half-up, which is half-away-from-zero once the sign is restored.
        scaled   = SW'(({1'b0, acc} + HALF_LSB) >> FRAC_BITS);
        mul_wrap = neg_q ? -scaled[W-1:0] : scaled[W-1:0];
        // A negative result may reach one step further than a positive one.
        mul_ovf  = neg_q ? (scaled > MAG_MIN) : (scaled > MAG_MAX);
        mul_res  = mul_wrap;
        if (SAT && mul_ovf) begin
            mul_res = neg_q ? MIN_W : MAX_W;
        end
    end

    // Control FSM together with the shift-add datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            result   <= '0;
            overflow <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MUL: begin
                                acc   <= '0;
                                mcand <= {{W{1'b0}}, mag_a};
                                mplr  <= mag_b;
                                cnt   <= CW'(W);
                                neg_q <= a[W-1] ^ b[W-1];
                                state <= ST_MUL;
                            end
                            OP_RSV: begin
                                result   <= '0;
                                overflow <= 1'b0;
                                state    <= ST_DONE;
                            end
                            default: begin
                                result   <= as_res;
                                overflow <= as_ovf;
                                state    <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt != '0) begin
                        if (mplr[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                        cnt   <= cnt - CW'(1);
                    end else begin
                        result   <= mul_res;
                        overflow <= mul_ovf;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode straight from the state register
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_ponto_fixo_alu_seq.sv
// Bench for ponto_fixo_alu_seq: directed Q4.4 scenarios on the main instance
// plus a randomized regression over W = 8, 12, 16 with both SAT settings,
// checked against an integer-arithmetic reference model.

module tb_ponto_fixo_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] a, b;
    logic [7:0] result;
    logic       overflow, busy, done;

    logic        r_start;
    logic [1:0]  r_op;
    logic [15:0] r_a, r_b;

    logic [7:0]  r0_res;
    logic [11:0] r1_res, r2_res;
    logic [15:0] r3_res, r4_res;
    logic        xo [5];
    logic        xb [5];
    logic        xd [5];
    logic [15:0] xr [5];

    int checks   = 0;
    int failures = 0;

    // Regression instance geometry: W, FRAC_BITS, SAT
    int cw [5] = '{8, 12, 12, 16, 16};
    int cf [5] = '{4, 7, 6, 8, 13};
    int cs [5] = '{0, 1, 0, 1, 0};

    ponto_fixo_alu_seq #(.INT_BITS(4), .FRAC_BITS(4), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .overflow(overflow), .busy(busy), .done(done));

    ponto_fixo_alu_seq #(.INT_BITS(4), .FRAC_BITS(4), .SAT(1'b0)) u_r0 (
        .clk(clk), .rst(rst), .start(r_start), .op(r_op), .a(r_a[7:0]), .b(r_b[7:0]),
        .result(r0_res), .overflow(xo[0]), .busy(xb[0]), .done(xd[0]));
    ponto_fixo_alu_seq #(.INT_BITS(5), .FRAC_BITS(7), .SAT(1'b1)) u_r1 (
        .clk(clk), .rst(rst), .start(r_start), .op(r_op), .a(r_a[11:0]), .b(r_b[11:0]),
        .result(r1_res), .overflow(xo[1]), .busy(xb[1]), .done(xd[1]));
    ponto_fixo_alu_seq #(.INT_BITS(6), .FRAC_BITS(6), .SAT(1'b0)) u_r2 (
        .clk(clk), .rst(rst), .start(r_start), .op(r_op), .a(r_a[11:0]), .b(r_b[11:0]),
        .result(r2_res), .overflow(xo[2]), .busy(xb[2]), .done(xd[2]));
    ponto_fixo_alu_seq #(.INT_BITS(8), .FRAC_BITS(8), .SAT(1'b1)) u_r3 (
        .clk(clk), .rst(rst), .start(r_start), .op(r_op), .a(r_a), .b(r_b),
        .result(r3_res), .overflow(xo[3]), .busy(xb[3]), .done(xd[3]));
    ponto_fixo_alu_seq #(.INT_BITS(3), .FRAC_BITS(13), .SAT(1'b0)) u_r4 (
        .clk(clk), .rst(rst), .start(r_start), .op(r_op), .a(r_a), .b(r_b),
        .result(r4_res), .overflow(xo[4]), .busy(xb[4]), .done(xd[4]));

    assign xr[0] = {8'h00, r0_res};
    assign xr[1] = {4'h0, r1_res};
    assign xr[2] = {4'h0, r2_res};
    assign xr[3] = r3_res;
    assign xr[4] = r4_res;

    // Reference: true signed value from plain integer arithmetic, then
    // range check and clamp/wrap. Returns overflow in bit 40, result below.
    function automatic longint model(int w, int f, int sat, logic [1:0] o,
                                     longint ua, longint ub);
        longint half, sa, sb, ma, mb, q, t, r;
        bit ovf;
        half = longint'(1) << (w - 1);
        sa = (ua >= half) ? ua - 2 * half : ua;
        sb = (ub >= half) ? ub - 2 * half : ub;
        case (o)
            2'b00: t = sa + sb;
            2'b01: t = sa - sb;
            2'b10: begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q  = (ma * mb + (longint'(1) << (f - 1))) / (longint'(1) << f);
                t  = ((sa < 0) != (sb < 0)) ? -q : q;
            end
            default: t = 0;
        endcase
        ovf = (t > half - 1) || (t < -half);
        if (ovf && sat != 0) t = (t > 0) ? half - 1 : -half;
        r = t & (2 * half - 1);
        return (ovf ? (longint'(1) << 40) : longint'(0)) | r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One operation on the main instance. lat counts edges after the
    // accepting edge until done is visible (-1 if it never shows).
    task automatic run_dut(input logic [1:0] o, input logic [7:0] va, vb,
                           output logic [7:0] res, output logic ov, output int lat);
        start = 1'b1; op = o; a = va; b = vb;
        tick;
        start = 1'b0;
        lat = -1; res = 8'hxx; ov = 1'bx;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                lat = n; res = result; ov = overflow;
                break;
            end
            tick;
        end
        tick;
    endtask

    logic [15:0] g_res [5];
    logic        g_ovf [5];
    int          g_lat [5];

    // One operation on all regression instances at once; operands are
    // scrambled right after acceptance to show the in-flight op is isolated.
    task automatic run_reg(input logic [1:0] o, input logic [15:0] va, vb);
        bit all;
        r_start = 1'b1; r_op = o; r_a = va; r_b = vb;
        tick;
        r_start = 1'b0;
        r_op = 2'($urandom); r_a = 16'($urandom); r_b = 16'($urandom);
        for (int i = 0; i < 5; i++) g_lat[i] = -1;
        for (int n = 0; n < 24; n++) begin
            all = 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (g_lat[i] < 0 && xd[i]) begin
                    g_lat[i] = n; g_res[i] = xr[i]; g_ovf[i] = xo[i];
                end
                if (g_lat[i] < 0) all = 1'b0;
            end
            if (all) break;
            tick;
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        checks++;
        if (result !== 8'h00 || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: result=%h ovf=%b busy=%b done=%b, want 00 0 0 0",
                     result, overflow, busy, done);
        end
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_add;
        logic [7:0] r; logic v; int l;
        run_dut(2'b00, 8'h18, 8'h24, r, v, l);
        checks++;
        if (r !== 8'h3C || v !== 1'b0) begin
            failures++;
            $display("FAIL add_basic: got %h/%b, want 3C/0", r, v);
        end
        checks++;
        if (l != 0) begin
            failures++;
            $display("FAIL add_latency: got %0d, want 0", l);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] r; logic v; int l;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (result !== 8'h00 || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: result=%h ovf=%b busy=%b done=%b, want zeros",
                     result, overflow, busy, done);
        end
        tick;
        rst = 1'b0;
        run_dut(2'b00, 8'h18, 8'h24, r, v, l);
        checks++;
        if (r !== 8'h3C || l != 0) begin
            failures++;
            $display("FAIL first_after_reset: got %h lat %0d, want 3C lat 0", r, l);
        end
    endtask

    task automatic test_add_overflow;
        logic [7:0] r; logic v; int l;
        run_dut(2'b00, 8'h70, 8'h10, r, v, l);
        checks++;
        if (r !== 8'h7F || v !== 1'b1) begin
            failures++;
            $display("FAIL add_ovf_sat: got %h/%b, want 7F/1", r, v);
        end
        run_reg(2'b00, 16'h0070, 16'h0010);
        checks++;
        if (g_res[0] !== 16'h0080 || g_ovf[0] !== 1'b1 || g_lat[0] != 0) begin
            failures++;
            $display("FAIL add_ovf_wrap: got %h/%b lat %0d, want 0080/1 lat 0",
                     g_res[0], g_ovf[0], g_lat[0]);
        end
    endtask

    task automatic test_sub;
        logic [7:0] r; logic v; int l;
        run_dut(2'b01, 8'h10, 8'h20, r, v, l);
        checks++;
        if (r !== 8'hF0 || v !== 1'b0 || l != 0) begin
            failures++;
            $display("FAIL sub_basic: got %h/%b lat %0d, want F0/0 lat 0", r, v, l);
        end
        run_dut(2'b01, 8'h80, 8'h10, r, v, l);
        checks++;
        if (r !== 8'h80 || v !== 1'b1) begin
            failures++;
            $display("FAIL sub_ovf: got %h/%b, want 80/1", r, v);
        end
    endtask

    task automatic test_mul;
        logic [7:0] ta [4] = '{8'h18, 8'hF8, 8'h40, 8'h80};
        logic [7:0] tb [4] = '{8'h20, 8'h01, 8'h40, 8'h80};
        logic [7:0] er [4] = '{8'h30, 8'hFF, 8'h7F, 8'h7F};
        logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] r; logic v; int l;
        for (int i = 0; i < 4; i++) begin
            run_dut(2'b10, ta[i], tb[i], r, v, l);
            checks++;
            if (r !== er[i] || v !== eo[i]) begin
                failures++;
                $display("FAIL mul_%0d: %h*%h got %h/%b, want %h/%b",
                         i, ta[i], tb[i], r, v, er[i], eo[i]);
            end
            checks++;
            if (l != 9) begin
                failures++;
                $display("FAIL mul_latency_%0d: got %0d, want 9", i, l);
            end
        end
    endtask

    task automatic test_reserved;
        logic [7:0] r; logic v; int l;
        run_dut(2'b11, 8'h55, 8'h33, r, v, l);
        checks++;
        if (r !== 8'h00 || v !== 1'b0 || l != 0) begin
            failures++;
            $display("FAIL reserved: got %h/%b lat %0d, want 00/0 lat 0", r, v, l);
        end
    endtask

    task automatic test_handshake;
        int seen = 0; int dl = -1; logic [7:0] dr = 8'h00;
        start = 1'b1; op = 2'b10; a = 8'h18; b = 8'h20;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            start = (n >= 2 && n <= 5);
            op = 2'b00;
            if (n == 3) a = 8'h7F;
            tick;
            if (n >= 2 && n <= 5) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_mid_mul: n=%0d got %b, want 1", n, busy);
                end
            end
            if (done) begin
                seen++; dl = n; dr = result;
            end
        end
        checks++;
        if (seen != 1 || dl != 9 || dr !== 8'h30) begin
            failures++;
            $display("FAIL ignore_start: dones=%0d at %0d res %h, want 1 at 9 res 30",
                     seen, dl, dr);
        end
    endtask

    task automatic test_back_to_back;
        start = 1'b1; op = 2'b00; a = 8'h18; b = 8'h24;
        tick;
        checks++;
        if (done !== 1'b1 || result !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_first: done=%b res=%h, want 1 3C", done, result);
        end
        a = 8'h10; b = 8'h20;
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_gap: done=%b busy=%b res=%h, want 0 0 3C", done, busy, result);
        end
        tick;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 8'h30) begin
            failures++;
            $display("FAIL b2b_second: done=%b res=%h, want 1 30", done, result);
        end
        tick;
    endtask

    task automatic test_reset_mid_mul;
        logic [7:0] r; logic v; int l; int seen = 0;
        start = 1'b1; op = 2'b10; a = 8'h18; b = 8'h20;
        tick;
        start = 1'b0;
        for (int n = 0; n < 4; n++) tick;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== 8'h00 || done !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_mul: busy=%b res=%h done=%b ovf=%b, want zeros",
                     busy, result, done, overflow);
        end
        tick;
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick;
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL no_done_after_abort: got %0d pulses, want 0", seen);
        end
        run_dut(2'b00, 8'h18, 8'h24, r, v, l);
        checks++;
        if (r !== 8'h3C || v !== 1'b0 || l != 0) begin
            failures++;
            $display("FAIL add_after_abort: got %h/%b lat %0d, want 3C/0 lat 0", r, v, l);
        end
    endtask

    task automatic test_regression;
        logic [1:0]  o;
        logic [15:0] va, vb, er;
        longint      m, mask;
        int          el;
        for (int k = 0; k < 60; k++) begin
            o  = 2'($urandom_range(0, 3));
            va = 16'($urandom);
            vb = 16'($urandom);
            if (k % 10 == 0) va = 16'h8000;
            if (k % 15 == 0) vb = 16'hFFFF;
            run_reg(o, va, vb);
            for (int i = 0; i < 5; i++) begin
                mask = (longint'(1) << cw[i]) - 1;
                m  = model(cw[i], cf[i], cs[i], o, longint'(va) & mask, longint'(vb) & mask);
                er = m[15:0];
                el = (o == 2'b10) ? cw[i] + 1 : 0;
                checks++;
                if (g_lat[i] < 0 || g_res[i] !== er || g_ovf[i] !== m[40]) begin
                    failures++;
                    $display("FAIL regr_value: inst %0d op %0d a=%h b=%h got %h/%b, want %h/%b",
                             i, o, va, vb, g_res[i], g_ovf[i], er, m[40]);
                end
                checks++;
                if (g_lat[i] != el) begin
                    failures++;
                    $display("FAIL regr_latency: inst %0d op %0d got %0d, want %0d",
                             i, o, g_lat[i], el);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
        r_start = 1'b0; r_op = 2'b00; r_a = 16'h0000; r_b = 16'h0000;
        test_reset;
        test_add;
        test_async_reset;
        test_add_overflow;
        test_sub;
        test_mul;
        test_reserved;
        test_handshake;
        test_back_to_back;
        test_reset_mid_mul;
        test_regression;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
